memory_unit: RTL and testbench

//  Responder side of the control::memory_op_e command interface. It executes commands issued by the

---
 rtl/memory_unit_if.sv | 45 ++++
 rtl/memory_unit.sv | 148 ++++++++++++++
 tb/tb_memory_unit.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : memory_unit_if
//  Description : Command and memory-port bundle for memory_unit.
//                slave  - memory_unit side (executes commands, drives memory)
//                master - control unit / memory macro side
//  Signals     : op_i/op_valid_i/op_ready_o  command handshake
//                data_i/data_o               operand in, last read data out
//                done_o/err_o                completion pulse, sticky error
//                addr_o                      MAR value / memory address
//                mem_req_o/mem_we_o/mem_wdata_o/mem_rdata_i/mem_ack_i
//                                            req/ack memory transaction port
//  Revision    : 1.0 - initial release
// ============================================================================
interface memory_unit_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8
);
    logic [2:0]        op_i;
    logic              op_valid_i;
    logic              op_ready_o;
    logic [DATA_W-1:0] data_i;
    logic [DATA_W-1:0] data_o;
    logic              done_o;
    logic              err_o;
    logic [ADDR_W-1:0] addr_o;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              mem_ack_i;

    modport slave (
        input  op_i, op_valid_i, data_i, mem_rdata_i, mem_ack_i,
        output op_ready_o, data_o, done_o, err_o, addr_o,
               mem_req_o, mem_we_o, mem_wdata_o
    );

    modport master (
        output op_i, op_valid_i, data_i, mem_rdata_i, mem_ack_i,
        input  op_ready_o, data_o, done_o, err_o, addr_o,
               mem_req_o, mem_we_o, mem_wdata_o
    );
endinterface
`default_nettype wire

// File: rtl/memory_unit.sv
`default_nettype none
// ============================================================================
//  Module      : memory_unit
//  Description : Responder for memory commands from the control unit. Owns the
//                memory address register (MAR), performs absolute/relative
//                address updates and runs READ/WRITE transactions on a req/ack
//                memory port with a timeout abort.
//  Ports       : clk  - system clock, rising edge
//                rst  - synchronous active-high reset
//                bus  - memory_unit_if.slave (command + memory port)
//  Revision    : 1.0 - initial release
// ============================================================================
module memory_unit #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  wire logic    clk,
    input  wire logic    rst,
    memory_unit_if.slave bus
);

    localparam logic [2:0] c_OP_NOP      = 3'd0;
    localparam logic [2:0] c_OP_READ     = 3'd1;
    localparam logic [2:0] c_OP_WRITE    = 3'd2;
    localparam logic [2:0] c_OP_ABSOLUTE = 3'd3;
    localparam logic [2:0] c_OP_REL_SUB  = 3'd4;
    localparam logic [2:0] c_OP_REL_ADD  = 3'd5;

    localparam logic [0:0] c_ST_IDLE   = 1'b0;
    localparam logic [0:0] c_ST_ACCESS = 1'b1;

    localparam int             CNT_W     = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [0:0]        state_q,  state_d;
    logic [ADDR_W-1:0] mar_q,    mar_d;
    logic [DATA_W-1:0] rdata_q,  rdata_d;
    logic [DATA_W-1:0] wdata_q,  wdata_d;
    logic              we_q,     we_d;
    logic              done_q,   done_d;
    logic              err_q,    err_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;

    logic              w_accept;
    logic [ADDR_W-1:0] w_operand;

    assign w_accept  = bus.op_valid_i && (state_q == c_ST_IDLE);
    assign w_operand = ADDR_W'(bus.data_i);   // zero-extend operand to MAR width

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_ST_IDLE;
            mar_q   <= '0;
            rdata_q <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
            rdata_q <= rdata_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath update
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        mar_d   = mar_q;
        rdata_d = rdata_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        done_d  = 1'b0;
        err_d   = err_q;
        cnt_d   = cnt_q;

        case (state_q)
            c_ST_IDLE: begin
                if (w_accept) begin
                    err_d  = 1'b0;
                    done_d = 1'b1;
                    case (bus.op_i)
                        c_OP_NOP:      ;
                        c_OP_ABSOLUTE: mar_d = w_operand;
                        // Relative updates wrap modulo 2^ADDR_W by construction
                        c_OP_REL_SUB:  mar_d = mar_q - w_operand;
                        c_OP_REL_ADD:  mar_d = mar_q + w_operand;
                        c_OP_READ, c_OP_WRITE: begin
                            state_d = c_ST_ACCESS;
                            we_d    = (bus.op_i == c_OP_WRITE);
                            wdata_d = bus.data_i;
                            cnt_d   = '0;
                            done_d  = 1'b0;
                        end
                        default:       err_d = 1'b1;
                    endcase
                end
            end
            c_ST_ACCESS: begin
                // Ack is checked first so an ack on the final cycle is not an error
                if (bus.mem_ack_i) begin
                    if (!we_q) begin
                        rdata_d = bus.mem_rdata_i;
                    end
                    state_d = c_ST_IDLE;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                end else if (cnt_q == c_CNT_LAST) begin
                    state_d = c_ST_IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        bus.op_ready_o  = (state_q == c_ST_IDLE);
        bus.mem_req_o   = (state_q == c_ST_ACCESS);
        bus.mem_we_o    = we_q && (state_q == c_ST_ACCESS);
        bus.mem_wdata_o = wdata_q;
        bus.addr_o      = mar_q;
        bus.data_o      = rdata_q;
        bus.done_o      = done_q;
        bus.err_o       = err_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_memory_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memory_unit
//  Description : Self-checking bench for memory_unit. Commands are driven on
//                the falling edge; expected completions go into a scoreboard
//                queue and are compared whenever done_o is seen. A small memory
//                model answers requests after a programmable number of cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_memory_unit;

    localparam int ADDR_W  = 9;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 16;

    localparam logic [2:0] c_NOP = 3'd0, c_READ = 3'd1, c_WRITE = 3'd2,
                           c_ABS = 3'd3, c_SUB  = 3'd4, c_ADD   = 3'd5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    memory_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    memory_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              err;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    logic [ADDR_W-1:0] mar_m  = '0;
    logic [DATA_W-1:0] data_m = '0;

    // Memory model controls
    int                ack_delay = 0;   // 0 = never acknowledge
    int                req_cnt   = 0;
    int                last_len  = 0;
    logic              model_ack = 1'b0;
    logic              late_ack  = 1'b0;
    logic [DATA_W-1:0] rd_val    = '0;
    logic              exp_we    = 1'b0;
    logic [DATA_W-1:0] exp_wdata = '0;
    int                n_done    = 0;

    assign bus.mem_ack_i   = model_ack | late_ack;
    assign bus.mem_rdata_i = rd_val;

    // Memory model: counts request cycles and checks held request attributes
    always @(negedge clk) begin
        if (bus.mem_req_o) begin
            req_cnt++;
            last_len = req_cnt;
            check_val("mem_we", 32'(bus.mem_we_o), 32'(exp_we));
            check_val("mem_addr", 32'(bus.addr_o), 32'(mar_m));
            if (exp_we) check_val("mem_wdata", 32'(bus.mem_wdata_o), 32'(exp_wdata));
            model_ack = (req_cnt == ack_delay);
        end else begin
            req_cnt   = 0;
            model_ack = 1'b0;
        end
    end

    // Completion monitor
    always @(negedge clk) begin
        if (!rst && bus.done_o) begin
            n_done++;
            check_val("done_ready", 32'(bus.op_ready_o), 32'd1);
            if (sb.size() == 0) begin
                check_val("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_val("addr_o", 32'(bus.addr_o), 32'(e.addr));
                check_val("data_o", 32'(bus.data_o), 32'(e.data));
                check_val("err_o",  32'(bus.err_o),  32'(e.err));
            end
        end
    end

    // Drive one command at a falling edge; returns one cycle after accept
    task automatic issue(input logic [2:0] op, input logic [DATA_W-1:0] d,
                         input logic [DATA_W-1:0] rd, input int delay);
        exp_t e;
        logic timeout;
        for (int i = 0; i < 60 && !bus.op_ready_o; i++) @(negedge clk);
        check_val("ready_wait", 32'(bus.op_ready_o), 32'd1);
        timeout = (delay == 0) || (delay > TIMEOUT);
        e.err   = 1'b0;
        case (op)
            c_NOP:   ;
            c_ABS:   mar_m = ADDR_W'(d);
            c_SUB:   mar_m = mar_m - ADDR_W'(d);
            c_ADD:   mar_m = mar_m + ADDR_W'(d);
            c_READ: begin
                exp_we = 1'b0; ack_delay = delay; rd_val = rd;
                if (timeout) e.err = 1'b1; else data_m = rd;
            end
            c_WRITE: begin
                exp_we = 1'b1; exp_wdata = d; ack_delay = delay;
                e.err = timeout;
            end
            default: e.err = 1'b1;
        endcase
        e.addr = mar_m;
        e.data = data_m;
        sb.push_back(e);
        bus.op_i       = op;
        bus.data_i     = d;
        bus.op_valid_i = 1'b1;
        @(negedge clk);
        bus.op_valid_i = 1'b0;
        bus.data_i     = 8'hEE;   // operand must only be sampled at accept
        if (op != c_READ && op != c_WRITE)
            check_val("addr_op_latency", 32'(bus.done_o), 32'd1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        check_val("drain", 32'(sb.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        bus.op_i       = c_NOP;
        bus.op_valid_i = 1'b0;
        bus.data_i     = '0;

        // 1: reset state
        repeat (3) @(negedge clk);
        check_val("rst_addr",  32'(bus.addr_o),     32'd0);
        check_val("rst_ready", 32'(bus.op_ready_o), 32'd1);
        check_val("rst_req",   32'(bus.mem_req_o),  32'd0);
        check_val("rst_done",  32'(bus.done_o),     32'd0);
        check_val("rst_err",   32'(bus.err_o),      32'd0);
        check_val("rst_data",  32'(bus.data_o),     32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 2: address arithmetic with 9-bit carry and wrap
        issue(c_ABS, 8'hF0, 8'h00, 0);
        issue(c_ADD, 8'h20, 8'h00, 0);
        wait_drain();
        check_val("add_carry", 32'(bus.addr_o), 32'h110);
        issue(c_ABS, 8'h10, 8'h00, 0);
        issue(c_SUB, 8'h20, 8'h00, 0);
        wait_drain();
        check_val("sub_wrap", 32'(bus.addr_o), 32'h1F0);
        issue(c_ADD, 8'hFF, 8'h00, 0);
        wait_drain();
        check_val("add_wrap", 32'(bus.addr_o), 32'h0EF);
        issue(c_ABS, 8'hF0, 8'h00, 0);
        issue(c_ADD, 8'h20, 8'h00, 0);
        wait_drain();

        // 3: WRITE with ack after 3 request cycles
        d0 = n_done;
        issue(c_WRITE, 8'hA5, 8'h00, 3);
        wait_drain();
        check_val("wr_req_len", 32'(last_len), 32'd3);
        check_val("wr_done_cnt", 32'(n_done - d0), 32'd1);
        check_val("wr_addr_held", 32'(bus.addr_o), 32'h110);

        // 4: READ with immediate ack, back-to-back command in the done cycle
        issue(c_READ, 8'h00, 8'h3C, 1);
        for (int i = 0; i < 40 && !bus.done_o; i++) @(negedge clk);
        check_val("rd_done_seen", 32'(bus.done_o), 32'd1);
        check_val("rd_req_len", 32'(last_len), 32'd1);
        issue(c_ABS, 8'h42, 8'h00, 0);
        wait_drain();
        check_val("b2b_addr", 32'(bus.addr_o), 32'h042);

        // 5: timeout without ack, then ack on the last allowed cycle
        issue(c_READ, 8'h00, 8'h77, 0);
        wait_drain();
        check_val("to_req_len", 32'(last_len), 32'd16);
        check_val("to_err", 32'(bus.err_o), 32'd1);
        issue(c_READ, 8'h00, 8'h5A, 16);
        wait_drain();
        check_val("late_ack_len", 32'(last_len), 32'd16);
        check_val("late_ack_data", 32'(bus.data_o), 32'h5A);
        issue(c_WRITE, 8'h81, 8'h00, 0);
        wait_drain();

        // 6: illegal ops, error cleared by next accept
        issue(3'd7, 8'h13, 8'h00, 0);
        issue(3'd6, 8'h24, 8'h00, 0);
        issue(c_NOP, 8'h00, 8'h00, 0);
        wait_drain();

        // Reset in the middle of an access
        d0 = n_done;
        issue(c_READ, 8'h00, 8'h99, 5);
        @(negedge clk);
        check_val("mid_req", 32'(bus.mem_req_o), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        mar_m  = '0;
        data_m = '0;
        check_val("rr_req",   32'(bus.mem_req_o),  32'd0);
        check_val("rr_ready", 32'(bus.op_ready_o), 32'd1);
        check_val("rr_addr",  32'(bus.addr_o),     32'd0);
        check_val("rr_data",  32'(bus.data_o),     32'd0);
        late_ack = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_val("late_req",  32'(bus.mem_req_o), 32'd0);
            check_val("late_done", 32'(bus.done_o),    32'd0);
        end
        late_ack = 1'b0;
        check_val("rr_done_cnt", 32'(n_done - d0), 32'd0);
        issue(c_ADD, 8'h05, 8'h00, 0);
        wait_drain();

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
